multi_monostable: RTL and testbench

Parametrised, multi-channel successor to the single-input one-pulse generator. Each of `CHANNELS` independent inputs is synchronised, edge-detected and debounced, then produces exactly one output pulse of run-time programmable length per qualified press, with optional retrigger (pulse extension). The block sits between raw button/strobe inputs and downstream control logic that needs clean, fixed-width single pulses.

---
 rtl/multi_monostable.sv | 134 +++++++++++++
 tb/tb_multi_monostable.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_monostable.sv
// rtl/multi_monostable.sv - multi-channel debounced one-shot pulse generator with optional retrigger
module multi_monostable #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int CNT_W           = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] din,
    input  logic [CNT_W-1:0]    pulse_len,
    input  logic                retrig_en,
    output logic [CHANNELS-1:0] dout,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] done
);

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PULSE    = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    logic [CHANNELS-1:0] sync1_q, sync1_d;
    logic [CHANNELS-1:0] din_s_q, din_s_d;
    logic [CHANNELS-1:0] din_d_q, din_d_d;
    logic [CNT_W-1:0]    len_eff;

    // A programmed length of zero still produces a one-cycle pulse.
    assign len_eff = (pulse_len == '0) ? CNT_W'(1) : pulse_len;

    always_comb begin
        sync1_d = din;
        din_s_d = sync1_q;
        din_d_d = din_s_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            din_s_q <= '0;
            din_d_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            din_s_q <= din_s_d;
            din_d_q <= din_d_d;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        state_t           state_q, state_d;
        logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
        logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
        logic             dout_q, dout_d;
        logic             busy_q, busy_d;
        logic             done_q, done_d;
        logic             rise;
        logic             lvl;

        assign lvl  = din_s_q[g];
        assign rise = din_s_q[g] & ~din_d_q[g];

        always_comb begin
            state_d     = state_q;
            db_cnt_d    = db_cnt_q;
            pulse_cnt_d = pulse_cnt_q;
            done_d      = 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d  = DEBOUNCE;
                        db_cnt_d = '0;
                    end
                end
                DEBOUNCE: begin
                    if (!lvl) begin
                        state_d = IDLE;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_d     = PULSE;
                        pulse_cnt_d = len_eff;
                    end else begin
                        db_cnt_d = db_cnt_q + DB_W'(1);
                    end
                end
                PULSE: begin
                    // Retrigger wins over expiry so an extension never emits a done strobe.
                    if (retrig_en && rise) begin
                        pulse_cnt_d = len_eff;
                    end else if (pulse_cnt_q == CNT_W'(1)) begin
                        state_d     = lvl ? WAIT_REL : IDLE;
                        pulse_cnt_d = '0;
                        done_d      = 1'b1;
                    end else begin
                        pulse_cnt_d = pulse_cnt_q - CNT_W'(1);
                    end
                end
                WAIT_REL: begin
                    if (!lvl) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            dout_d = (state_d == PULSE);
            busy_d = (state_d != IDLE);
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q     <= IDLE;
                db_cnt_q    <= '0;
                pulse_cnt_q <= '0;
                dout_q      <= 1'b0;
                busy_q      <= 1'b0;
                done_q      <= 1'b0;
            end else begin
                state_q     <= state_d;
                db_cnt_q    <= db_cnt_d;
                pulse_cnt_q <= pulse_cnt_d;
                dout_q      <= dout_d;
                busy_q      <= busy_d;
                done_q      <= done_d;
            end
        end

        assign dout[g] = dout_q;
        assign busy[g] = busy_q;
        assign done[g] = done_q;
    end

endmodule

// File: tb/tb_multi_monostable.sv
// tb/tb_multi_monostable.sv - directed self-checking bench for multi_monostable
module tb_multi_monostable;

    logic       clk;
    logic       reset;
    logic [3:0] din;
    logic [7:0] pulse_len;
    logic       retrig_en;
    logic [3:0] dout;
    logic [3:0] busy;
    logic [3:0] done;

    int tests;
    int fails;

    int first_hi, n_hi, n_pulses, n_done, first_done, n_busy, n_other;
    int n_all_hi, n_all_done, last_busy;

    multi_monostable #(
        .CHANNELS        (4),
        .DEBOUNCE_CYCLES (2),
        .CNT_W           (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .pulse_len (pulse_len),
        .retrig_en (retrig_en),
        .dout      (dout),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Observe n negedges; sample k is the state after edge E_k, where E_0 is the first edge.
    // If drop >= 0, din[ch] is low for edge E_drop only and high again from E_(drop+1).
    task automatic watch(input int ch, input int n, input int drop);
        logic prev;
        first_hi = -1; n_hi = 0; n_pulses = 0; n_done = 0; first_done = -1;
        n_busy = 0; n_other = 0; n_all_hi = 0; n_all_done = 0;
        prev = dout[ch];
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (dout[ch]) begin
                n_hi++;
                if (first_hi < 0) first_hi = k;
                if (!prev) n_pulses++;
            end
            prev = dout[ch];
            if (done[ch]) begin
                n_done++;
                if (first_done < 0) first_done = k;
            end
            if (busy[ch]) n_busy++;
            if (((dout | busy | done) & ~(4'b1 << ch)) != 4'b0) n_other++;
            if (dout == 4'hF) n_all_hi++;
            if (done == 4'hF) n_all_done++;
            last_busy = int'(busy[ch]);
            if (drop >= 0 && k + 1 == drop) din[ch] = 1'b0;
            if (drop >= 0 && k + 1 == drop + 1) din[ch] = 1'b1;
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        din = 4'b0;
        pulse_len = 8'd5;
        retrig_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_dout", int'(dout), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // ch0: held 20 cycles, pulse_len 5
        din[0] = 1'b1;
        watch(0, 20, -1);
        chk("t1_first_hi", first_hi, 4);
        chk("t1_n_hi", n_hi, 5);
        chk("t1_pulses", n_pulses, 1);
        chk("t1_n_done", n_done, 1);
        chk("t1_done_at_fall", first_done, 9);
        chk("t1_others_quiet", n_other, 0);
        din[0] = 1'b0;
        @(negedge clk);
        chk("t1_busy_E20", int'(busy[0]), 1);
        @(negedge clk);
        chk("t1_busy_E21", int'(busy[0]), 1);
        @(negedge clk);
        chk("t1_busy_E22", int'(busy[0]), 0);
        repeat (3) @(negedge clk);

        // ch1: one sampled cycle glitch
        din[1] = 1'b1;
        @(negedge clk);
        din[1] = 1'b0;
        watch(1, 10, -1);
        chk("t2_n_hi", n_hi, 0);
        chk("t2_n_done", n_done, 0);
        chk("t2_n_busy", n_busy, 1);
        chk("t2_idle", last_busy, 0);

        // ch2: held 50 cycles, pulse_len 3
        pulse_len = 8'd3;
        din[2] = 1'b1;
        watch(2, 50, -1);
        chk("t3_first_hi", first_hi, 4);
        chk("t3_n_hi", n_hi, 3);
        chk("t3_pulses", n_pulses, 1);
        chk("t3_n_done", n_done, 1);
        chk("t3_wait_rel_busy", last_busy, 1);
        din[2] = 1'b0;
        repeat (5) @(negedge clk);
        chk("t3_released", int'(busy[2]), 0);

        pulse_len = 8'd0;
        din[2] = 1'b1;
        watch(2, 12, -1);
        chk("t3z_first_hi", first_hi, 4);
        chk("t3z_n_hi", n_hi, 1);
        chk("t3z_n_done", n_done, 1);
        din[2] = 1'b0;
        repeat (5) @(negedge clk);

        // ch3 retrigger: din low for E7 only, rise visible in pulse cycle 6
        retrig_en = 1'b1;
        pulse_len = 8'd8;
        din[3] = 1'b1;
        watch(3, 40, 7);
        chk("t4r_first_hi", first_hi, 4);
        chk("t4r_n_hi", n_hi, 14);
        chk("t4r_pulses", n_pulses, 1);
        chk("t4r_n_done", n_done, 1);
        chk("t4r_done_at", first_done, 18);
        din[3] = 1'b0;
        repeat (5) @(negedge clk);

        retrig_en = 1'b0;
        din[3] = 1'b1;
        watch(3, 40, 7);
        chk("t4n_n_hi", n_hi, 8);
        chk("t4n_pulses", n_pulses, 1);
        chk("t4n_n_done", n_done, 1);
        chk("t4n_done_at", first_done, 12);
        chk("t4n_wait_rel", last_busy, 1);
        din[3] = 1'b0;
        repeat (5) @(negedge clk);

        // all channels together, pulse_len 4
        pulse_len = 8'd4;
        din = 4'hF;
        watch(0, 15, -1);
        chk("t5_first_hi", first_hi, 4);
        chk("t5_n_hi", n_hi, 4);
        chk("t5_all_hi", n_all_hi, 4);
        chk("t5_all_done", n_all_done, 1);
        chk("t5_n_done", n_done, 1);
        din = 4'h0;
        repeat (5) @(negedge clk);

        // reset mid-pulse with din held high
        pulse_len = 8'd5;
        din[0] = 1'b1;
        repeat (6) @(negedge clk);
        chk("t6_pulsing", int'(dout[0]), 1);
        reset = 1'b0;
        #1;
        chk("t6_rst_dout", int'(dout), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_done", int'(done), 0);
        watch(0, 3, -1);
        chk("t6_rst_no_done", n_done, 0);
        chk("t6_rst_no_hi", n_hi, 0);
        reset = 1'b1;
        watch(0, 15, -1);
        chk("t6_first_hi", first_hi, 4);
        chk("t6_n_hi", n_hi, 5);
        chk("t6_n_done", n_done, 1);
        din[0] = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
